mdio_rx_multi: RTL and testbench
================================

Name: mdio_rx_multi

Overview:
- Parametrised MDIO (Clause 22) management receiver on the PHY side of the management interface.
- Deserialises host frames on MDC, decodes read and write operations, and serves a contiguous range of NUM_PHY PHY addresses instead of a single one.
- Write frames are delivered as a one-cycle strobe toward the register bank.
- Read frames fetch RD_DATA through a request pulse and shift it back onto the line; malformed frames are flagged.

Parameters:
- PHY_BASE, 5'd1, first PHY address served.
- NUM_PHY, 4, number of consecutive PHY addresses served (1..31; PHY_BASE+NUM_PHY-1 <= 31).
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST is accepted (1..32).
- IDX_W, max(1,clog2(NUM_PHY)), derived width of PHY_IDX.

Ports:
- MDC  in  1  management clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MDIO_OUT  in  1  serial bit driven by the host.
- MDIO_OE  in  1  host drive enable; when 0 the line reads as 1 (pull-up).
- RD_DATA  in  16  read data, sampled one cycle after RD_REQ.
- MDIO_IN  out  1  serial bit driven back to the host.
- MDIO_IN_EN  out  1  slave drive enable.
- ADDR  out  5  register address of the current frame.
- PHY_IDX  out  IDX_W  matched PHYAD minus PHY_BASE.
- WR_DATA  out  16  captured write data.
- WR_STB  out  1  one-cycle write strobe.
- RD_REQ  out  1  one-cycle read request.
- MDIO_DONE  out  1  one-cycle end-of-frame pulse for any accepted frame.
- FRAME_ERR  out  1  one-cycle malformed-frame pulse.
- WR_BCAST  out  1  broadcast qualifier; valid with WR_STB.

Behaviour:
- Effective input bit: b = MDIO_OE ? MDIO_OUT : 1, sampled each rising MDC.
- Reset (async, any time including mid-frame): all outputs 0; MDIO_IN_EN released immediately; state PRE; preamble count 0.

State machine:
- PRE: count consecutive b=1, saturating at PREAMBLE_LEN; b=0 clears the count. A 0 seen with count==PREAMBLE_LEN is ST bit0 -> ST.
- ST: require b=1 -> OP. Else FRAME_ERR -> PRE.
- OP: 2 bits. 10 = read, 01 = write, 00/11 -> FRAME_ERR -> PRE.
- PHYAD: 5 bits, MSB first.
- REGAD: 5 bits, MSB first.
- Edge sampling the last REGAD bit: match = PHYAD in [PHY_BASE, PHY_BASE+NUM_PHY-1]. ADDR and PHY_IDX update on this edge.
  - Read & match: RD_REQ=1 for this cycle -> TA_R.
  - Write & match: -> TA_W.
  - No match: -> SKIP.
- TA_R: first edge latches RD_DATA into the shift register. Second cycle: MDIO_IN_EN=1, MDIO_IN=0. Then RDATA.
- RDATA: 16 cycles driving MSB first, MDIO_IN_EN=1.
  - Edge after the last bit: MDIO_IN_EN=0, MDIO_DONE=1 -> PRE.
  - Total drive window: 17 MDC cycles.
- TA_W: 2 bits, must be 1,0; else FRAME_ERR -> SKIP.
- WDATA: 16 bits, MSB first. Edge sampling bit 15: WR_DATA updated, WR_STB=1, MDIO_DONE=1 the same cycle -> PRE.
- SKIP: count the remaining 18 bit times (TA + data), no outputs, -> PRE.
- Preamble counter restarts from 0 after every frame. Back-to-back frames need a full new preamble.
- ADDR, PHY_IDX, WR_DATA hold their value until the next accepted frame.
- Strobes are never asserted simultaneously, except WR_STB with MDIO_DONE (and WR_BCAST).
- MDIO_OE=1 during TA_R or RDATA is host contention: ignored, slave keeps driving.

Optional Feature:
- Macro MDIO_RX_BCAST_EN.
- Defined:
  - Write frames with PHYAD=0 are accepted even if 0 is outside the range.
  - WR_STB fires with WR_BCAST=1 and PHY_IDX=0.
  - Read frames to PHYAD=0 are skipped (no drive), avoiding multi-slave contention.
- Undefined:
  - PHYAD=0 is handled like any other address.
  - WR_BCAST is tied 0.

Test Plan:
- Write, PHY_BASE=4, NUM_PHY=2: 32 ones, ST=01, OP=01, PHYAD=5, REGAD=0x1F, TA=10, data 0xABCD -> exactly one WR_STB cycle with PHY_IDX=1, ADDR=0x1F, WR_DATA=0xABCD, MDIO_DONE=1; MDIO_IN_EN never 1.
- Read, PHYAD=4, REGAD=0x03, RD_DATA=0xDCBA:
  - RD_REQ one cycle after the last REGAD edge.
  - MDIO_IN_EN high 17 cycles; MDIO_IN=0 then 1101_1100_1011_1010.
  - MDIO_DONE after release.
- Preamble of 31 ones (PREAMBLE_LEN=32) then a valid write frame -> no WR_STB. Address mismatch PHYAD=7 -> no strobe, no drive, next valid frame accepted.
- Write frame with TA=11 -> FRAME_ERR one cycle, no WR_STB. OP=00 -> FRAME_ERR, return to PRE.
- RESET asserted at data bit 8 of a read -> MDIO_IN_EN drops without waiting for MDC. After release, a full read frame works normally.
- With MDIO_RX_BCAST_EN:
  - Write to PHYAD=0 -> WR_STB with WR_BCAST=1.
  - Read to PHYAD=0 -> no drive.
  - Without the macro, both are ignored when 0 is out of range.

Source files
------------

// File: rtl/mdio_rx_multi.sv
// MDIO Clause 22 PHY-side receiver serving NUM_PHY consecutive PHY addresses from PHY_BASE.
// Define MDIO_RX_BCAST_EN to accept PHYAD 0 as a write broadcast; reads to PHYAD 0 are then ignored.
module mdio_rx_multi #(
  parameter logic [4:0] PHY_BASE     = 5'd1,
  parameter int         NUM_PHY      = 4,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         IDX_W        = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1
) (
  input  logic             MDC,
  input  logic             RESET,
  input  logic             MDIO_OUT,
  input  logic             MDIO_OE,
  input  logic [15:0]      RD_DATA,
  output logic             MDIO_IN,
  output logic             MDIO_IN_EN,
  output logic [4:0]       ADDR,
  output logic [IDX_W-1:0] PHY_IDX,
  output logic [15:0]      WR_DATA,
  output logic             WR_STB,
  output logic             RD_REQ,
  output logic             MDIO_DONE,
  output logic             FRAME_ERR,
  output logic             WR_BCAST
);
  typedef enum logic [3:0] {
    S_PRE, S_ST, S_OP, S_ADR, S_TA_R, S_RDATA, S_TA_W, S_WDATA, S_SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  state_t           state_q, state_d;
  logic [5:0]       pre_cnt_q, pre_cnt_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      sh_q, sh_d;
  logic             rd_q, rd_d;
  logic             bcast_q, bcast_d;
  logic             mdio_in_q, mdio_in_d;
  logic             mdio_in_en_q, mdio_in_en_d;
  logic [4:0]       addr_q, addr_d;
  logic [IDX_W-1:0] phy_idx_q, phy_idx_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             wr_stb_q, wr_stb_d;
  logic             rd_req_q, rd_req_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
  logic             wr_bcast_q, wr_bcast_d;

  logic       b;
  logic [4:0] phyad, regad;
  logic       in_rng, is_bc, accept;

  assign b      = MDIO_OE ? MDIO_OUT : 1'b1;
  // On the last REGAD edge the shift register holds PHYAD and the first four REGAD bits.
  assign phyad  = sh_q[8:4];
  assign regad  = {sh_q[3:0], b};
  assign in_rng = (int'(phyad) >= int'(PHY_BASE)) && (int'(phyad) < int'(PHY_BASE) + NUM_PHY);

`ifdef MDIO_RX_BCAST_EN
  assign is_bc  = (phyad == 5'd0);
  assign accept = rd_q ? (in_rng && !is_bc) : (in_rng || is_bc);
`else
  assign is_bc  = 1'b0;
  assign accept = in_rng;
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    rd_d         = rd_q;
    bcast_d      = bcast_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_en_d = mdio_in_en_q;
    addr_d       = addr_q;
    phy_idx_d    = phy_idx_q;
    wr_data_d    = wr_data_q;
    wr_stb_d     = 1'b0;
    rd_req_d     = 1'b0;
    done_d       = 1'b0;
    frame_err_d  = 1'b0;
    wr_bcast_d   = 1'b0;
    case (state_q)
      S_PRE: begin
        if (b) begin
          if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
        end else begin
          pre_cnt_d = '0;
          if (pre_cnt_q == PRE_MAX) state_d = S_ST;
        end
      end
      S_ST: begin
        if (b) begin
          state_d = S_OP;
          cnt_d   = '0;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_PRE;
        end
      end
      S_OP: begin
        sh_d = {sh_q[14:0], b};
        if (cnt_q == 5'd0) begin
          cnt_d = 5'd1;
        end else begin
          cnt_d = '0;
          // 10 = read, 01 = write: the first opcode bit is the read flag.
          if (sh_q[0] != b) begin
            rd_d    = sh_q[0];
            state_d = S_ADR;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_PRE;
          end
        end
      end
      S_ADR: begin
        sh_d  = {sh_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd9) begin
          cnt_d = '0;
          if (accept) begin
            addr_d    = regad;
            phy_idx_d = is_bc ? '0 : IDX_W'(phyad - PHY_BASE);
            bcast_d   = is_bc;
            rd_req_d  = rd_q;
            state_d   = rd_q ? S_TA_R : S_TA_W;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_TA_R: begin
        if (cnt_q == 5'd0) begin
          sh_d         = RD_DATA;
          mdio_in_en_d = 1'b1;
          mdio_in_d    = 1'b0;
          cnt_d        = 5'd1;
        end else begin
          mdio_in_d = sh_q[15];
          sh_d      = {sh_q[14:0], 1'b0};
          cnt_d     = '0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (cnt_q == 5'd15) begin
          mdio_in_en_d = 1'b0;
          mdio_in_d    = 1'b0;
          done_d       = 1'b1;
          cnt_d        = '0;
          state_d      = S_PRE;
        end else begin
          mdio_in_d = sh_q[15];
          sh_d      = {sh_q[14:0], 1'b0};
          cnt_d     = cnt_q + 5'd1;
        end
      end
      S_TA_W: begin
        sh_d = {sh_q[14:0], b};
        if (cnt_q == 5'd0) begin
          cnt_d = 5'd1;
        end else if ({sh_q[0], b} == 2'b10) begin
          cnt_d   = '0;
          state_d = S_WDATA;
        end else begin
          // Both TA bit times are already consumed; skip the 16 data bits.
          frame_err_d = 1'b1;
          cnt_d       = 5'd2;
          state_d     = S_SKIP;
        end
      end
      S_WDATA: begin
        sh_d  = {sh_q[14:0], b};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          wr_data_d  = {sh_q[14:0], b};
          wr_stb_d   = 1'b1;
          done_d     = 1'b1;
          wr_bcast_d = bcast_q;
          cnt_d      = '0;
          state_d    = S_PRE;
        end
      end
      S_SKIP: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd17) begin
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      default: state_d = S_PRE;
    endcase
  end

  always_ff @(posedge MDC or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_PRE;
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      sh_q         <= '0;
      rd_q         <= 1'b0;
      bcast_q      <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_in_en_q <= 1'b0;
      addr_q       <= '0;
      phy_idx_q    <= '0;
      wr_data_q    <= '0;
      wr_stb_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_bcast_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      rd_q         <= rd_d;
      bcast_q      <= bcast_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_en_q <= mdio_in_en_d;
      addr_q       <= addr_d;
      phy_idx_q    <= phy_idx_d;
      wr_data_q    <= wr_data_d;
      wr_stb_q     <= wr_stb_d;
      rd_req_q     <= rd_req_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      wr_bcast_q   <= wr_bcast_d;
    end
  end

  assign MDIO_IN    = mdio_in_q;
  assign MDIO_IN_EN = mdio_in_en_q;
  assign ADDR       = addr_q;
  assign PHY_IDX    = phy_idx_q;
  assign WR_DATA    = wr_data_q;
  assign WR_STB     = wr_stb_q;
  assign RD_REQ     = rd_req_q;
  assign MDIO_DONE  = done_q;
  assign FRAME_ERR  = frame_err_q;
  assign WR_BCAST   = wr_bcast_q;
endmodule

// File: tb/tb_mdio_rx_multi.sv
// Bench for mdio_rx_multi (PHY_BASE=4, NUM_PHY=2): directed and random frames against a frame-level model.
module tb_mdio_rx_multi;
  localparam logic [4:0] BASE = 5'd4;
  localparam int NPHY = 2;
  localparam int PLEN = 32;
  localparam int IW = 1;
`ifdef MDIO_RX_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic          MDC = 1'b0;
  logic          RESET, MDIO_OUT, MDIO_OE;
  logic [15:0]   RD_DATA;
  logic          MDIO_IN, MDIO_IN_EN;
  logic [4:0]    ADDR;
  logic [IW-1:0] PHY_IDX;
  logic [15:0]   WR_DATA;
  logic          WR_STB, RD_REQ, MDIO_DONE, FRAME_ERR, WR_BCAST;

  mdio_rx_multi #(.PHY_BASE(BASE), .NUM_PHY(NPHY), .PREAMBLE_LEN(PLEN)) dut (
    .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA),
    .MDIO_IN(MDIO_IN), .MDIO_IN_EN(MDIO_IN_EN), .ADDR(ADDR), .PHY_IDX(PHY_IDX),
    .WR_DATA(WR_DATA), .WR_STB(WR_STB), .RD_REQ(RD_REQ), .MDIO_DONE(MDIO_DONE),
    .FRAME_ERR(FRAME_ERR), .WR_BCAST(WR_BCAST)
  );

  always #5 MDC = ~MDC;

  int checks = 0;
  int failures = 0;

  // Per-frame observations
  int edge_n = 0;
  int wr_n, wr_at, rq_n, rq_at, done_n, done_at, err_n, en_n, en_first;
  int overlap_n = 0;
  logic [16:0]   drv_bits;
  logic [4:0]    wr_addr;
  logic [IW-1:0] wr_idx;
  logic [15:0]   wr_dat;
  logic          wr_bc;
  logic [15:0]   rd_val;

  // Model of the held register-bank outputs
  logic [4:0]    m_addr;
  logic [IW-1:0] m_idx;
  logic [15:0]   m_wdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_n = 0; wr_at = -1; rq_n = 0; rq_at = -1; done_n = 0; done_at = -1;
    err_n = 0; en_n = 0; en_first = -1; drv_bits = '0;
    wr_addr = '0; wr_idx = '0; wr_dat = '0; wr_bc = 1'b0;
  endtask

  // One MDC bit time: drive, wait for the edge, observe 1ns later.
  task automatic step(input logic oe, input logic v);
    MDIO_OE = oe;
    MDIO_OUT = v;
    @(posedge MDC);
    #1;
    edge_n++;
    if (WR_STB) begin
      wr_n++; wr_at = edge_n; wr_addr = ADDR; wr_idx = PHY_IDX; wr_dat = WR_DATA; wr_bc = WR_BCAST;
    end
    if (RD_REQ) begin rq_n++; rq_at = edge_n; end
    if (MDIO_DONE) begin done_n++; done_at = edge_n; end
    if (FRAME_ERR) err_n++;
    if (MDIO_IN_EN) begin
      if (en_n == 0) en_first = edge_n;
      en_n++;
      drv_bits = {drv_bits[15:0], MDIO_IN};
    end
    if ((RD_REQ && (WR_STB || MDIO_DONE || FRAME_ERR)) || (FRAME_ERR && (WR_STB || MDIO_DONE)) ||
        (WR_STB && !MDIO_DONE) || (WR_BCAST && !WR_STB) || (MDIO_IN_EN && WR_STB))
      overlap_n++;
    // Read data is only valid on the edge right after the request.
    RD_DATA = RD_REQ ? rd_val : 16'($urandom);
  endtask

  task automatic send(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                      input logic [4:0] phy, input logic [4:0] rg, input logic [1:0] ta,
                      input logic [15:0] dat, input logic contend, input int post_bits,
                      output int e0);
    logic [17:0] tail;
    tail = {ta, dat};
    clear_mon();
    for (int i = 0; i < pre_len; i++) step(1'b1, 1'b1);
    step(1'b1, st[1]); step(1'b1, st[0]);
    step(1'b1, op[1]); step(1'b1, op[0]);
    for (int i = 4; i >= 0; i--) step(1'b1, phy[i]);
    for (int i = 4; i >= 0; i--) step(1'b1, rg[i]);
    e0 = edge_n;
    for (int i = 0; i < post_bits; i++) begin
      if (op == 2'b10) step(contend, 1'($urandom));
      else step(1'b1, tail[17-i]);
    end
  endtask

  task automatic do_frame(input string tag, input int pre_len, input logic [1:0] st,
                          input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [1:0] ta, input logic [15:0] dat, input logic contend);
    int e0;
    bit synced, is_rd, is_wr, in_rng, bc, acc, e_wr, e_rq, e_err;
    rd_val = dat;
    send(pre_len, st, op, phy, rg, ta, dat, contend, 18, e0);
    synced = (pre_len >= PLEN);
    is_rd  = synced && st == 2'b01 && op == 2'b10;
    is_wr  = synced && st == 2'b01 && op == 2'b01;
    in_rng = (int'(phy) >= int'(BASE)) && (int'(phy) < int'(BASE) + NPHY);
    bc     = BC && (phy == 5'd0);
    acc    = is_rd ? (in_rng && !bc) : (is_wr && (in_rng || bc));
    e_rq   = acc && is_rd;
    e_wr   = acc && is_wr && ta == 2'b10;
    e_err  = (synced && st != 2'b01) || (synced && st == 2'b01 && !is_rd && !is_wr) ||
             (acc && is_wr && ta != 2'b10);
    if (acc) begin
      m_addr = rg;
      m_idx  = bc ? '0 : IW'(phy - BASE);
    end
    if (e_wr) m_wdat = dat;
    chk({tag, ".wr_stb_n"}, wr_n, e_wr ? 1 : 0);
    chk({tag, ".rd_req_n"}, rq_n, e_rq ? 1 : 0);
    chk({tag, ".done_n"}, done_n, (e_wr || e_rq) ? 1 : 0);
    chk({tag, ".frame_err_n"}, err_n, e_err ? 1 : 0);
    chk({tag, ".drive_cycles"}, en_n, e_rq ? 17 : 0);
    chk({tag, ".addr"}, ADDR, m_addr);
    chk({tag, ".phy_idx"}, PHY_IDX, m_idx);
    chk({tag, ".wr_data"}, WR_DATA, m_wdat);
    if (e_wr) begin
      chk({tag, ".wr_at"}, wr_at, e0 + 18);
      chk({tag, ".wr_addr"}, wr_addr, rg);
      chk({tag, ".wr_idx"}, wr_idx, m_idx);
      chk({tag, ".wr_dat"}, wr_dat, dat);
      chk({tag, ".wr_bcast"}, wr_bc, bc);
    end
    if (e_rq) begin
      chk({tag, ".rq_at"}, rq_at, e0);
      chk({tag, ".drive_first"}, en_first, e0 + 1);
      chk({tag, ".drive_bits"}, drv_bits, {1'b0, dat});
      chk({tag, ".done_at"}, done_at, e0 + 18);
    end
  endtask

  initial begin
    int e0, kind, pl;
    logic [4:0] phy, rg;
    logic [1:0] op, ta;
    logic [15:0] dat;

    RESET = 1'b1; MDIO_OE = 1'b0; MDIO_OUT = 1'b0; RD_DATA = '0; rd_val = '0;
    m_addr = '0; m_idx = '0; m_wdat = '0;
    clear_mon();
    repeat (3) @(posedge MDC);
    #1;
    chk("reset_outputs", {MDIO_IN, MDIO_IN_EN, ADDR, PHY_IDX, WR_DATA, WR_STB, RD_REQ,
                          MDIO_DONE, FRAME_ERR, WR_BCAST}, 32'd0);
    @(negedge MDC);
    RESET = 1'b0;

    do_frame("wr_phy5", 32, 2'b01, 2'b01, 5'd5, 5'h1F, 2'b10, 16'hABCD, 1'b0);
    do_frame("rd_phy4", 32, 2'b01, 2'b10, 5'd4, 5'h03, 2'b00, 16'hDCBA, 1'b0);
    do_frame("short_pre", 31, 2'b01, 2'b01, 5'd4, 5'h07, 2'b10, 16'h1357, 1'b0);
    do_frame("miss_phy7", 32, 2'b01, 2'b01, 5'd7, 5'h05, 2'b10, 16'h2468, 1'b0);
    do_frame("wr_after_miss", 32, 2'b01, 2'b01, 5'd4, 5'h0C, 2'b10, 16'hFFFF, 1'b0);
    do_frame("ta_11", 32, 2'b01, 2'b01, 5'd5, 5'h09, 2'b11, 16'h0F0F, 1'b0);
    do_frame("op_00", 32, 2'b01, 2'b00, 5'd4, 5'h02, 2'b10, 16'h1111, 1'b0);
    do_frame("st_00", 32, 2'b00, 2'b01, 5'd4, 5'h02, 2'b10, 16'h2222, 1'b0);
    do_frame("long_pre_rd", 40, 2'b01, 2'b10, 5'd5, 5'h15, 2'b00, 16'h8001, 1'b1);
    do_frame("wr_phy0", 32, 2'b01, 2'b01, 5'd0, 5'h04, 2'b10, 16'h7E57, 1'b0);
    do_frame("rd_phy0", 32, 2'b01, 2'b10, 5'd0, 5'h06, 2'b00, 16'hBEEF, 1'b0);

    // Reset while data bit 8 of a read is on the line.
    rd_val = 16'h5A3C;
    send(32, 2'b01, 2'b10, 5'd5, 5'h0A, 2'b00, rd_val, 1'b0, 9, e0);
    chk("rst.drive_cycles_before", en_n, 9);
    chk("rst.bit8_before", MDIO_IN, rd_val[8]);
    #2 RESET = 1'b1;
    #1;
    chk("rst.drive_released", MDIO_IN_EN, 1'b0);
    chk("rst.outputs", {MDIO_IN, MDIO_IN_EN, ADDR, PHY_IDX, WR_DATA, WR_STB, RD_REQ,
                        MDIO_DONE, FRAME_ERR, WR_BCAST}, 32'd0);
    @(negedge MDC);
    RESET = 1'b0;
    m_addr = '0; m_idx = '0; m_wdat = '0;
    do_frame("rd_after_rst", 32, 2'b01, 2'b10, 5'd4, 5'h11, 2'b00, 16'h1234, 1'b0);

    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 5);
      pl   = $urandom_range(32, 36);
      rg   = 5'($urandom);
      dat  = 16'($urandom);
      phy  = BASE + 5'($urandom_range(0, NPHY - 1));
      case (kind)
        0: do_frame("rnd_wr", pl, 2'b01, 2'b01, phy, rg, 2'b10, dat, 1'b0);
        1: do_frame("rnd_rd", pl, 2'b01, 2'b10, phy, rg, 2'b00, dat, 1'b0);
        2: begin
          phy = 5'($urandom_range(6, 31));
          op  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
          do_frame("rnd_miss", pl, 2'b01, op, phy, rg, 2'b10, dat, 1'b0);
        end
        3: begin
          ta = 2'($urandom_range(0, 2));
          if (ta == 2'b10) ta = 2'b11;
          do_frame("rnd_ta_err", pl, 2'b01, 2'b01, phy, rg, ta, dat, 1'b0);
        end
        4: begin
          op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
          do_frame("rnd_op_err", pl, 2'b01, op, phy, rg, 2'b10, dat, 1'b0);
        end
        default: do_frame("rnd_rd_contend", pl, 2'b01, 2'b10, phy, rg, 2'b00, dat, 1'b1);
      endcase
    end

    chk("strobe_overlap", overlap_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
